sensor_requester: RTL and testbench

Client-side request initiator for the sensor link: the host-end counterpart of the FPGA sensor responder. It latches a request code and device address, transmits them as two UART bytes through a byte-level UART transmitter, then collects the two-byte reply (response code, data) from a UART receiver. It sits between the client control logic (switches, buttons or soft CPU) and the `UART_TX`/`UART_RX` byte engines on the client board, and guards every wait with a cycle timeout.

---
 rtl/sensor_requester.sv | 206 ++++++++++++++++++++
 tb/tb_sensor_requester.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_requester.sv
// sensor_requester
//
// Host-end request initiator for the sensor link. An accepted start latches a request code
// and a device address and sends them as two bytes through a byte-level UART transmitter.
// The block then collects the two-byte reply (response code, then data) from a UART
// receiver. Every wait state is guarded by a cycle timeout.
//
// Optional feature: define SENSOR_REQUESTER_RETRY_EN to resend the request once after the
// first timeout of a transaction. With the macro undefined, the first timeout aborts.
//
// Parameters
//   TIMEOUT_CYCLES  maximum cycles spent in any wait state before aborting (minimum 2)
//
// Ports
//   clock           system clock, rising edge
//   reset           synchronous active-high reset
//   start           request strobe, sampled only while idle
//   request_code    request byte, latched on an accepted start
//   device_address  sensor address byte, latched on an accepted start
//   busy            high from the cycle after an accepted start until back in idle
//   tx_has_data     one-cycle strobe to the UART transmitter
//   tx_data         byte for the UART transmitter, held until its tx_done
//   tx_done         UART transmitter byte-complete pulse
//   rx_has_data     UART receiver byte-valid pulse
//   rx_data         UART receiver byte
//   response_code   first reply byte of the last completed transaction
//   response_data   second reply byte of the last completed transaction
//   response_valid  one-cycle pulse when both reply bytes have been captured
//   timed_out       one-cycle pulse when a transaction aborts

module sensor_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] request_code,
    input  logic [7:0] device_address,
    output logic       busy,
    output logic       tx_has_data,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       rx_has_data,
    input  logic [7:0] rx_data,
    output logic [7:0] response_code,
    output logic [7:0] response_data,
    output logic       response_valid,
    output logic       timed_out
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitCodeDone,
        StWaitAddrDone,
        StWaitResp0,
        StWaitResp1
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      addr_q;
    logic [7:0]      resp0_q;
    logic            busy_q;
    logic            tx_has_data_q;
    logic [7:0]      tx_data_q;
    logic [7:0]      response_code_q;
    logic [7:0]      response_data_q;
    logic            response_valid_q;
    logic            timed_out_q;
`ifdef SENSOR_REQUESTER_RETRY_EN
    logic [7:0]      code_q;
    logic            retried_q;
`endif

    logic event_hit;
    logic expire;

    // An advancing event always beats the timeout terminal in the same cycle.
    always_comb begin
        event_hit = 1'b0;
        case (state_q)
            StWaitCodeDone, StWaitAddrDone: event_hit = tx_done;
            StWaitResp0, StWaitResp1:       event_hit = rx_has_data;
            default:                        event_hit = 1'b0;
        endcase
        expire = (state_q != StIdle) && !event_hit && (cnt_q == CntLast);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            addr_q           <= 8'h00;
            resp0_q          <= 8'h00;
            busy_q           <= 1'b0;
            tx_has_data_q    <= 1'b0;
            tx_data_q        <= 8'h00;
            response_code_q  <= 8'h00;
            response_data_q  <= 8'h00;
            response_valid_q <= 1'b0;
            timed_out_q      <= 1'b0;
`ifdef SENSOR_REQUESTER_RETRY_EN
            code_q           <= 8'h00;
            retried_q        <= 1'b0;
`endif
        end else begin
            tx_has_data_q    <= 1'b0;
            response_valid_q <= 1'b0;
            timed_out_q      <= 1'b0;

            if (expire) begin
                cnt_q <= '0;
`ifdef SENSOR_REQUESTER_RETRY_EN
                if (!retried_q) begin
                    // First stall of this transaction: replay both request bytes.
                    retried_q     <= 1'b1;
                    tx_data_q     <= code_q;
                    tx_has_data_q <= 1'b1;
                    state_q       <= StWaitCodeDone;
                end else begin
                    timed_out_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
`else
                timed_out_q <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= StIdle;
`endif
            end else begin
                case (state_q)
                    StIdle: begin
                        cnt_q <= '0;
                        if (start) begin
                            addr_q        <= device_address;
                            tx_data_q     <= request_code;
                            tx_has_data_q <= 1'b1;
                            busy_q        <= 1'b1;
                            state_q       <= StWaitCodeDone;
`ifdef SENSOR_REQUESTER_RETRY_EN
                            code_q        <= request_code;
                            retried_q     <= 1'b0;
`endif
                        end
                    end
                    StWaitCodeDone: begin
                        if (tx_done) begin
                            cnt_q         <= '0;
                            tx_data_q     <= addr_q;
                            tx_has_data_q <= 1'b1;
                            state_q       <= StWaitAddrDone;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StWaitAddrDone: begin
                        if (tx_done) begin
                            cnt_q   <= '0;
                            state_q <= StWaitResp0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StWaitResp0: begin
                        if (rx_has_data) begin
                            cnt_q   <= '0;
                            resp0_q <= rx_data;
                            state_q <= StWaitResp1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StWaitResp1: begin
                        if (rx_has_data) begin
                            cnt_q            <= '0;
                            response_code_q  <= resp0_q;
                            response_data_q  <= rx_data;
                            response_valid_q <= 1'b1;
                            busy_q           <= 1'b0;
                            state_q          <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy           = busy_q;
    assign tx_has_data    = tx_has_data_q;
    assign tx_data        = tx_data_q;
    assign response_code  = response_code_q;
    assign response_data  = response_data_q;
    assign response_valid = response_valid_q;
    assign timed_out      = timed_out_q;

endmodule

// File: tb/tb_sensor_requester.sv
// Directed bench for sensor_requester with TIMEOUT_CYCLES = 100. Inputs are driven 1 ns
// after each rising edge and outputs are sampled at the same point.

module tb_sensor_requester;

    localparam int unsigned TO = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] request_code;
    logic [7:0] device_address;
    logic       busy;
    logic       tx_has_data;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_has_data;
    logic [7:0] rx_data;
    logic [7:0] response_code;
    logic [7:0] response_data;
    logic       response_valid;
    logic       timed_out;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;
    int base;
    int early;

    sensor_requester #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .request_code  (request_code),
        .device_address(device_address),
        .busy          (busy),
        .tx_has_data   (tx_has_data),
        .tx_data       (tx_data),
        .tx_done       (tx_done),
        .rx_has_data   (rx_has_data),
        .rx_data       (rx_data),
        .response_code (response_code),
        .response_data (response_data),
        .response_valid(response_valid),
        .timed_out     (timed_out)
    );

    always #5 clock = ~clock;

    // Counts transmit strobes seen at each rising edge.
    always @(posedge clock) if (tx_has_data) strobes++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Start pulse plus both tx_done pulses; leaves the DUT just entered WAIT_RESP0.
    task automatic send_req(input logic [7:0] code, input logic [7:0] addr);
        start = 1'b1;
        request_code = code;
        device_address = addr;
        step();
        start = 1'b0;
        check_eq("req_strobe1", 32'(tx_has_data), 1);
        check_eq("req_byte1", 32'(tx_data), 32'(code));
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_eq("req_strobe2", 32'(tx_has_data), 1);
        check_eq("req_byte2", 32'(tx_data), 32'(addr));
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic reply(input logic [7:0] b);
        rx_has_data = 1'b1;
        rx_data = b;
        step();
        rx_has_data = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic count_silence(input int cycles);
        early = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (timed_out) early++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        request_code = 8'h00;
        device_address = 8'h00;
        tx_done = 1'b0;
        rx_has_data = 1'b0;
        rx_data = 8'h00;
        step();
        step();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_tx_has_data", 32'(tx_has_data), 0);
        check_eq("rst_tx_data", 32'(tx_data), 0);
        check_eq("rst_resp_code", 32'(response_code), 0);
        check_eq("rst_resp_data", 32'(response_data), 0);
        check_eq("rst_resp_valid", 32'(response_valid), 0);
        check_eq("rst_timed_out", 32'(timed_out), 0);
        reset = 1'b0;
        step();

        // Basic transaction with 10-cycle transmitter latency.
        base = strobes;
        start = 1'b1;
        request_code = 8'h01;
        device_address = 8'h05;
        step();
        start = 1'b0;
        check_eq("basic_busy", 32'(busy), 1);
        check_eq("basic_strobe1", 32'(tx_has_data), 1);
        check_eq("basic_byte1", 32'(tx_data), 32'h01);
        step();
        check_eq("basic_strobe_width", 32'(tx_has_data), 0);
        repeat (8) step();
        check_eq("basic_byte1_hold", 32'(tx_data), 32'h01);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_eq("basic_strobe2", 32'(tx_has_data), 1);
        check_eq("basic_byte2", 32'(tx_data), 32'h05);
        repeat (9) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        reply(8'h09);
        check_eq("basic_no_early_valid", 32'(response_valid), 0);
        reply(8'h1A);
        check_eq("basic_valid", 32'(response_valid), 1);
        check_eq("basic_code", 32'(response_code), 32'h09);
        check_eq("basic_data", 32'(response_data), 32'h1A);
        check_eq("basic_busy_low", 32'(busy), 0);
        step();
        check_eq("basic_valid_width", 32'(response_valid), 0);
        check_eq("basic_strobe_count", 32'(strobes - base), 2);

        // No reply: timeout exactly TO cycles after entering WAIT_RESP0.
        send_req(8'h01, 8'h05);
        count_silence(TO - 1);
        check_eq("noreply_early_timeout", 32'(early), 0);
        step();
`ifdef SENSOR_REQUESTER_RETRY_EN
        check_eq("retry_timed_out", 32'(timed_out), 0);
        check_eq("retry_busy", 32'(busy), 1);
        check_eq("retry_strobe1", 32'(tx_has_data), 1);
        check_eq("retry_byte1", 32'(tx_data), 32'h01);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_eq("retry_byte2", 32'(tx_data), 32'h05);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        count_silence(TO - 1);
        check_eq("retry_early_timeout", 32'(early), 0);
        step();
`endif
        check_eq("noreply_timed_out", 32'(timed_out), 1);
        check_eq("noreply_busy", 32'(busy), 0);
        check_eq("noreply_valid", 32'(response_valid), 0);
        check_eq("noreply_code_kept", 32'(response_code), 32'h09);
        check_eq("noreply_data_kept", 32'(response_data), 32'h1A);
        step();
        check_eq("noreply_pulse_width", 32'(timed_out), 0);

        // Stray traffic: RX byte in IDLE, start and RX pulses while busy.
        rx_has_data = 1'b1;
        rx_data = 8'h55;
        step();
        rx_has_data = 1'b0;
        check_eq("stray_idle_busy", 32'(busy), 0);
        check_eq("stray_idle_valid", 32'(response_valid), 0);
        base = strobes;
        start = 1'b1;
        request_code = 8'h21;
        device_address = 8'h42;
        step();
        request_code = 8'hEE;
        device_address = 8'hDD;
        rx_has_data = 1'b1;
        rx_data = 8'h55;
        step();
        start = 1'b0;
        rx_has_data = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_eq("stray_byte2", 32'(tx_data), 32'h42);
        start = 1'b1;
        step();
        start = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        reply(8'h33);
        reply(8'h44);
        check_eq("stray_valid", 32'(response_valid), 1);
        check_eq("stray_code", 32'(response_code), 32'h33);
        check_eq("stray_data", 32'(response_data), 32'h44);
        step();
        check_eq("stray_strobe_count", 32'(strobes - base), 2);

        // Race: second reply byte on the timeout terminal cycle.
        send_req(8'h05, 8'h06);
        reply(8'h11);
        count_silence(TO - 1);
        check_eq("race_early_timeout", 32'(early), 0);
        reply(8'h22);
        check_eq("race_valid", 32'(response_valid), 1);
        check_eq("race_timed_out", 32'(timed_out), 0);
        check_eq("race_code", 32'(response_code), 32'h11);
        check_eq("race_data", 32'(response_data), 32'h22);
        step();
        check_eq("race_late_timeout", 32'(timed_out), 0);

        // Reset while in WAIT_RESP1, then a clean request.
        send_req(8'h0A, 8'h0B);
        reply(8'h5A);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_tx_has_data", 32'(tx_has_data), 0);
        check_eq("midrst_tx_data", 32'(tx_data), 0);
        check_eq("midrst_resp_code", 32'(response_code), 0);
        check_eq("midrst_resp_data", 32'(response_data), 0);
        check_eq("midrst_valid", 32'(response_valid), 0);
        check_eq("midrst_timed_out", 32'(timed_out), 0);
        send_req(8'h02, 8'h03);
        reply(8'h77);
        reply(8'h88);
        check_eq("postrst_valid", 32'(response_valid), 1);
        check_eq("postrst_code", 32'(response_code), 32'h77);
        check_eq("postrst_data", 32'(response_data), 32'h88);

        // Back-to-back: start held high across completion.
        step();
        start = 1'b1;
        request_code = 8'h10;
        device_address = 8'h20;
        step();
        check_eq("b2b_byte1", 32'(tx_data), 32'h10);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_eq("b2b_byte2", 32'(tx_data), 32'h20);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        reply(8'hAB);
        reply(8'hCD);
        check_eq("b2b_valid", 32'(response_valid), 1);
        check_eq("b2b_busy_low", 32'(busy), 0);
        check_eq("b2b_data", 32'(response_data), 32'hCD);
        request_code = 8'h11;
        device_address = 8'h21;
        step();
        start = 1'b0;
        check_eq("b2b_restart_strobe", 32'(tx_has_data), 1);
        check_eq("b2b_restart_byte1", 32'(tx_data), 32'h11);
        check_eq("b2b_restart_busy", 32'(busy), 1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check_eq("b2b_restart_byte2", 32'(tx_data), 32'h21);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        reply(8'h01);
        reply(8'h02);
        check_eq("b2b_second_code", 32'(response_code), 32'h01);
        check_eq("b2b_second_data", 32'(response_data), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
